// File: rtl/shift_add_mult_sched.sv
// rtl/shift_add_mult_sched.sv - round-robin shared shift-and-add multiplier for two requesters
// Optional SHIFT_ADD_EARLY_DONE_EN ends RUN once the remaining multiplier bits are all zero.
module shift_add_mult_sched #(
   parameter int M = 4,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic [M-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [M-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic         req1_ready,
   output logic         res_valid,
   output logic         res_id,
   output logic [M+N-1:0] res_product,
   input  logic         res_ready,
   output logic         busy
);
   localparam int W  = M + N;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic            id_q, id_d;
   logic [W-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [W-1:0]    res_product_q, res_product_d;
   logic            res_id_q, res_id_d;
   logic            grant1;
   logic            last_iter;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         last_grant_q  <= 1'b1;
         id_q          <= 1'b0;
         a_q           <= '0;
         b_q           <= '0;
         acc_q         <= '0;
         count_q       <= '0;
         res_product_q <= '0;
         res_id_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         id_q          <= id_d;
         a_q           <= a_d;
         b_q           <= b_d;
         acc_q         <= acc_d;
         count_q       <= count_d;
         res_product_q <= res_product_d;
         res_id_q      <= res_id_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      id_d          = id_q;
      a_d           = a_q;
      b_d           = b_q;
      acc_d         = acc_q;
      count_d       = count_q;
      res_product_d = res_product_q;
      res_id_d      = res_id_q;
      last_iter     = 1'b0;

      // Requester 1 wins when alone, or on contention when requester 0 was served last.
      grant1     = req1_valid && (!req0_valid || !last_grant_q);
      req0_ready = (state_q == IDLE) && !rst && req0_valid && !grant1;
      req1_ready = (state_q == IDLE) && !rst && grant1;

      case (state_q)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               a_d          = W'(grant1 ? req1_a : req0_a);
               b_d          = grant1 ? req1_b : req0_b;
               acc_d        = '0;
               count_d      = '0;
               id_d         = grant1;
               last_grant_d = grant1;
               state_d      = RUN;
            end
         end
         RUN: begin
`ifdef SHIFT_ADD_EARLY_DONE_EN
            if (b_q == '0) begin
               state_d       = DONE;
               res_product_d = acc_q;
               res_id_d      = id_q;
            end else begin
               acc_d     = acc_q + (b_q[0] ? a_q : '0);
               a_d       = a_q << 1;
               b_d       = b_q >> 1;
               count_d   = count_q + 1'b1;
               last_iter = (count_q == CW'(N - 1)) || ((b_q >> 1) == '0);
            end
`else
            acc_d     = acc_q + (b_q[0] ? a_q : '0);
            a_d       = a_q << 1;
            b_d       = b_q >> 1;
            count_d   = count_q + 1'b1;
            last_iter = (count_q == CW'(N - 1));
`endif
            if (last_iter) begin
               state_d       = DONE;
               res_product_d = acc_d;
               res_id_d      = id_q;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign res_valid   = (state_q == DONE);
   assign res_id      = res_id_q;
   assign res_product = res_product_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_shift_add_mult_sched.sv
// tb/tb_shift_add_mult_sched.sv - randomized self-checking bench for shift_add_mult_sched
// Expected latency follows SHIFT_ADD_EARLY_DONE_EN when the bench is built with it.
module tb_shift_add_mult_sched;
   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req1_valid;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic       req0_ready, req1_ready;
   logic       res_valid, res_id, res_ready, busy;
   logic [7:0] res_product;

   int errors = 0;
   int checks = 0;
   int last_m = 1;

   always #5 clk = ~clk;

   shift_add_mult_sched #(.M(4), .N(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .res_valid(res_valid), .res_id(res_id), .res_product(res_product),
      .res_ready(res_ready), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input int b);
`ifdef SHIFT_ADD_EARLY_DONE_EN
      int h;
      h = -1;
      for (int i = 0; i < 4; i++) if (b[i]) h = i;
      return h + 1 + ((h < 0) ? 1 : 0);
`else
      return 4;
`endif
   endfunction

   task automatic run_op(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                         input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                         input int bp);
      int g, lat, cnt, ep;
      g   = (v0 && v1) ? (1 - last_m) : (v1 ? 1 : 0);
      ep  = g ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
      lat = exp_lat(g ? int'(b1) : int'(b0));
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      res_ready  = (bp == 0);
      #1;
      check("req0_ready_grant", req0_ready, (g == 0));
      check("req1_ready_grant", req1_ready, (g == 1));
      @(posedge clk);
      last_m = g;
      @(negedge clk);
      req0_a = 4'($urandom); req0_b = 4'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom);
      cnt = 1;
      check("busy_run", busy, 1);
      while (!res_valid && cnt < 30) begin
         @(negedge clk);
         cnt++;
      end
      check("latency", cnt, lat + 1);
      check("res_valid", res_valid, 1);
      check("res_product", res_product, ep);
      check("res_id", res_id, g);
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         check("bp_valid", res_valid, 1);
         check("bp_product", res_product, ep);
         check("bp_id", res_id, g);
         check("bp_ready", {req0_ready, req1_ready}, 0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      check("consumed_valid", res_valid, 0);
      check("consumed_busy", busy, 0);
      check("held_product", res_product, ep);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      last_m = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic v0, v1;
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 4'd1; req0_b = 4'd1; req1_a = 4'd1; req1_b = 4'd1;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", res_valid, 0);
      check("rst_product", res_product, 0);
      check("rst_id", res_id, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", {req0_ready, req1_ready}, 0);
      rst = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);

      run_op(1, 4'd15, 4'd15, 0, 4'd0, 4'd0, 0);
      run_op(0, 4'd0, 4'd0, 1, 4'd3, 4'd3, 0);
      run_op(1, 4'd12, 4'd2, 0, 4'd0, 4'd0, 0);

      do_reset();
      run_op(1, 4'd2, 4'd5, 1, 4'd7, 4'd7, 0);
      run_op(1, 4'd2, 4'd5, 1, 4'd7, 4'd7, 0);
      run_op(1, 4'd2, 4'd5, 1, 4'd7, 4'd7, 0);
      run_op(1, 4'd2, 4'd5, 1, 4'd7, 4'd7, 0);

      run_op(0, 4'd0, 4'd0, 1, 4'd11, 4'd13, 6);

      req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd15;
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      req1_valid = 1'b1;
      @(negedge clk);
      check("abort_valid", res_valid, 0);
      check("abort_product", res_product, 0);
      check("abort_id", res_id, 0);
      check("abort_busy", busy, 0);
      check("abort_ready", {req0_ready, req1_ready}, 0);
      rst = 1'b0;
      req1_valid = 1'b0;
      last_m = 1;
      run_op(0, 4'd0, 4'd0, 1, 4'd3, 4'd3, 0);

      run_op(1, 4'd12, 4'd2, 0, 4'd0, 4'd0, 0);
      run_op(1, 4'd9, 4'd0, 0, 4'd0, 4'd0, 0);
      run_op(0, 4'd0, 4'd0, 1, 4'd5, 4'd1, 1);

      for (int k = 0; k < 40; k++) begin
         v0 = 1'($urandom);
         v1 = 1'($urandom);
         if (!v0 && !v1) v0 = 1'b1;
         run_op(v0, 4'($urandom), 4'($urandom), v1, 4'($urandom), 4'($urandom),
                int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
